// File: rtl/ddr2_cmd_issuer_if.sv
// ddr2_cmd_issuer_if: request handshake plus DFI control bundle for the DDR2 command issuer
interface ddr2_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_ba;
    logic [14:0] cmd_addr;
    logic        dfi_cke;
    logic [1:0]  dfi_cs_n;
    logic        dfi_ras_n;
    logic        dfi_cas_n;
    logic        dfi_we_n;
    logic [1:0]  dfi_ba;
    logic [14:0] dfi_addr;
    logic        cmd_err;
    logic [3:0]  bank_open;
    modport master (
        output cmd_valid, cmd_op, cmd_ba, cmd_addr,
        input  cmd_ready, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr,
        input  cmd_err, bank_open
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_ba, cmd_addr,
        output cmd_ready, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr,
        output cmd_err, bank_open
    );
endinterface

// File: rtl/ddr2_cmd_issuer.sv
// ddr2_cmd_issuer: timing-checked DDR2 command acceptance and registered issue onto the DFI control bus
module ddr2_cmd_issuer #(
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_RAS = 12,
    parameter int T_RFC = 26,
    parameter int T_CCD = 2
) (
    input logic          clk,
    input logic          rst,
    ddr2_cmd_issuer_if.slave bus
);
    localparam int M1    = T_RCD > T_RP ? T_RCD : T_RP;
    localparam int M2    = M1 > T_RAS ? M1 : T_RAS;
    localparam int M3    = M2 > T_RFC ? M2 : T_RFC;
    localparam int T_MAX = M3 > T_CCD ? M3 : T_CCD;
    localparam int W     = $clog2(T_MAX) + 1;
    typedef logic [W-1:0] tmr_t;
    localparam tmr_t L_RCD = tmr_t'(T_RCD - 1);
    localparam tmr_t L_RP  = tmr_t'(T_RP - 1);
    localparam tmr_t L_RAS = tmr_t'(T_RAS - 1);
    localparam tmr_t L_RFC = tmr_t'(T_RFC - 1);
    localparam tmr_t L_CCD = tmr_t'(T_CCD - 1);
    localparam logic [2:0] OP_ACT = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_PRE = 3'd3, OP_PREA = 3'd4, OP_REF = 3'd5;

    logic        cke;
    logic [3:0]  open_q;
    tmr_t        rcd [4];
    tmr_t        ras [4];
    tmr_t        rp  [4];
    tmr_t        rfc, ccd;
    logic [2:0]  op;
    logic [1:0]  ba;
    logic        is_cas, illegal, gate_ok, ready, accept, issue;
    logic [3:0]  ras_busy, rp_busy;
    logic [1:0]  cs_d, ba_d;
    logic        ras_d, cas_d, we_d;
    logic [14:0] addr_d;

    function automatic tmr_t dec(input tmr_t t);
        return (t == '0) ? t : t - tmr_t'(1);
    endfunction

    for (genvar b = 0; b < 4; b++) begin : g_busy
        assign ras_busy[b] = |ras[b];
        assign rp_busy[b]  = |rp[b];
    end

    assign op      = bus.cmd_op;
    assign ba      = bus.cmd_ba;
    assign is_cas  = op == OP_RD || op == OP_WR;
    assign illegal = op > OP_REF || (op == OP_ACT && open_q[ba]) || (is_cas && !open_q[ba]) ||
                     (op == OP_REF && |open_q);
    // A PRE to an already closed bank is a harmless no-op and bypasses every timer
    assign gate_ok = op == OP_ACT  ? !rp_busy[ba] && rfc == '0
                   : is_cas        ? rcd[ba] == '0 && ccd == '0 && rfc == '0
                   : op == OP_PRE  ? !open_q[ba] || (!ras_busy[ba] && rfc == '0)
                   : op == OP_PREA ? !(|(ras_busy & open_q)) && rfc == '0
                   : !(|rp_busy) && rfc == '0;
    assign ready   = cke && !rst && (illegal || gate_ok);
    assign accept  = ready && bus.cmd_valid;
    assign issue   = accept && !illegal;

    assign bus.cmd_ready = ready;
    assign bus.dfi_cke   = cke;
    assign bus.bank_open = open_q;

    always_comb begin
        cs_d   = 2'b11;
        ras_d  = 1'b1;
        cas_d  = 1'b1;
        we_d   = 1'b1;
        ba_d   = '0;
        addr_d = '0;
        if (issue) begin
            cs_d = 2'b10;
            case (op)
                OP_ACT: begin
                    ras_d  = 1'b0;
                    ba_d   = ba;
                    addr_d = bus.cmd_addr;
                end
                OP_RD, OP_WR: begin
                    cas_d  = 1'b0;
                    we_d   = op == OP_RD;
                    ba_d   = ba;
                    addr_d = bus.cmd_addr & ~15'h400;
                end
                OP_PRE: begin
                    ras_d = 1'b0;
                    we_d  = 1'b0;
                    ba_d  = ba;
                end
                OP_PREA: begin
                    ras_d  = 1'b0;
                    we_d   = 1'b0;
                    addr_d = 15'h400;
                end
                default: begin
                    ras_d = 1'b0;
                    cas_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cke           <= 1'b0;
            bus.dfi_cs_n  <= 2'b11;
            bus.dfi_ras_n <= 1'b1;
            bus.dfi_cas_n <= 1'b1;
            bus.dfi_we_n  <= 1'b1;
            bus.dfi_ba    <= '0;
            bus.dfi_addr  <= '0;
            bus.cmd_err   <= 1'b0;
            open_q        <= '0;
            rfc           <= '0;
            ccd           <= '0;
            for (int b = 0; b < 4; b++) begin
                rcd[b] <= '0;
                ras[b] <= '0;
                rp[b]  <= '0;
            end
        end else begin
            cke           <= 1'b1;
            bus.dfi_cs_n  <= cs_d;
            bus.dfi_ras_n <= ras_d;
            bus.dfi_cas_n <= cas_d;
            bus.dfi_we_n  <= we_d;
            bus.dfi_ba    <= ba_d;
            bus.dfi_addr  <= addr_d;
            bus.cmd_err   <= accept && illegal;
            rfc           <= (issue && op == OP_REF) ? L_RFC : dec(rfc);
            ccd           <= (issue && is_cas) ? L_CCD : dec(ccd);
            for (int b = 0; b < 4; b++) begin
                rcd[b]    <= (issue && op == OP_ACT && ba == 2'(b)) ? L_RCD : dec(rcd[b]);
                ras[b]    <= (issue && op == OP_ACT && ba == 2'(b)) ? L_RAS : dec(ras[b]);
                rp[b]     <= (issue && open_q[b] && (op == OP_PREA || (op == OP_PRE && ba == 2'(b)))) ?
                             L_RP : dec(rp[b]);
                open_q[b] <= (issue && op == OP_ACT && ba == 2'(b)) ? 1'b1 :
                             (issue && (op == OP_PREA || (op == OP_PRE && ba == 2'(b)))) ? 1'b0 : open_q[b];
            end
        end
    end
endmodule

// File: tb/tb_ddr2_cmd_issuer.sv
// tb_ddr2_cmd_issuer: directed and random checks of ddr2_cmd_issuer against a timestamp-based model
module tb_ddr2_cmd_issuer;
    localparam int T_RCD = 4, T_RP = 4, T_RAS = 12, T_RFC = 26, T_CCD = 2;
    localparam logic [21:0] IDLE = {2'b11, 3'b111, 2'b00, 15'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr2_cmd_issuer_if bus ();
    ddr2_cmd_issuer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC), .T_CCD(T_CCD))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int          cyc = 0, vectors = 0, errs = 0;
    int          act_t [4];
    int          rp_t [4];
    int          cas_t, ref_t;
    logic [3:0]  open_m;
    logic        cke_m, exp_err, last_acc;
    logic [21:0] exp_dfi;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        open_m  = '0;
        cke_m   = 1'b0;
        exp_err = 1'b0;
        exp_dfi = IDLE;
        cas_t   = -1000;
        ref_t   = -1000;
        for (int b = 0; b < 4; b++) begin
            act_t[b] = -1000;
            rp_t[b]  = -1000;
        end
    endfunction

    function automatic bit is_illegal(input logic [2:0] op, input logic [1:0] ba);
        return op > 5 || (op == 0 && open_m[ba]) || ((op == 1 || op == 2) && !open_m[ba]) ||
               (op == 5 && open_m != 0);
    endfunction

    function automatic bit timing_ok(input logic [2:0] op, input logic [1:0] ba);
        bit ok = cyc >= ref_t + T_RFC;
        case (op)
            0: ok = ok && cyc >= rp_t[ba] + T_RP;
            1, 2: ok = ok && cyc >= act_t[ba] + T_RCD && cyc >= cas_t + T_CCD;
            3: ok = !open_m[ba] || (ok && cyc >= act_t[ba] + T_RAS);
            4: for (int b = 0; b < 4; b++) if (open_m[b] && cyc < act_t[b] + T_RAS) ok = 0;
            default: for (int b = 0; b < 4; b++) if (cyc < rp_t[b] + T_RP) ok = 0;
        endcase
        return ok;
    endfunction

    function automatic logic [21:0] enc(input logic [2:0] op, input logic [1:0] ba, input logic [14:0] a);
        case (op)
            0: return {2'b10, 3'b011, ba, a};
            1: return {2'b10, 3'b101, ba, a & 15'h7bff};
            2: return {2'b10, 3'b100, ba, a & 15'h7bff};
            3: return {2'b10, 3'b010, ba, 15'h0};
            4: return {2'b10, 3'b010, 2'b00, 15'h400};
            default: return {2'b10, 3'b001, 2'b00, 15'h0};
        endcase
    endfunction

    function automatic logic [21:0] dfi_now();
        return {bus.dfi_cs_n, bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n, bus.dfi_ba, bus.dfi_addr};
    endfunction

    task automatic tick();
        logic [2:0] op = bus.cmd_op;
        logic [1:0] ba = bus.cmd_ba;
        bit ill, rdy, acc;
        @(negedge clk);
        ill = is_illegal(op, ba);
        rdy = !rst && cke_m && (ill || timing_ok(op, ba));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(rdy));
        chk("dfi", 32'(dfi_now()), 32'(exp_dfi));
        chk("cmd_err", 32'(bus.cmd_err), 32'(exp_err));
        chk("bank_open", 32'(bus.bank_open), 32'(open_m));
        chk("dfi_cke", 32'(bus.dfi_cke), 32'(cke_m));
        acc = rdy && bus.cmd_valid;
        if (rst) model_reset();
        else begin
            cke_m   = 1'b1;
            exp_err = acc && ill;
            exp_dfi = (acc && !ill) ? enc(op, ba, bus.cmd_addr) : IDLE;
            if (acc && !ill) begin
                case (op)
                    0: begin act_t[ba] = cyc; open_m[ba] = 1'b1; end
                    1, 2: cas_t = cyc;
                    3: if (open_m[ba]) begin rp_t[ba] = cyc; open_m[ba] = 1'b0; end
                    4: begin
                        for (int b = 0; b < 4; b++) if (open_m[b]) rp_t[b] = cyc;
                        open_m = '0;
                    end
                    default: ref_t = cyc;
                endcase
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] ba, input logic [14:0] a, output int acc);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_ba    = ba;
        bus.cmd_addr  = a;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 64);
        chk("accept_bound", 32'(last_acc), 32'd1);
        acc = cyc - 1;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int n0, t0, t1, t2;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_ba    = '0;
        bus.cmd_addr  = '0;
        last_acc      = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        // ACT bank 1 row 0x1234 and its registered DFI image
        issue(3'd0, 2'd1, 15'h1234, t0);
        chk("act_dfi", 32'(dfi_now()), 32'({2'b10, 3'b011, 2'd1, 15'h1234}));
        chk("act_open", 32'(bus.bank_open), 32'h2);
        tick();
        chk("act_idle", 32'(dfi_now()), 32'(IDLE));
        // tRCD then tCCD
        issue(3'd0, 2'd0, 15'h0042, t0);
        issue(3'd1, 2'd0, 15'h7fff, t1);
        chk("rd_trcd", 32'(t1 - t0), 32'd4);
        chk("rd_a10", 32'(bus.dfi_addr), 32'h7bff);
        issue(3'd2, 2'd0, 15'h0010, t2);
        chk("wr_tccd", 32'(t2 - t1), 32'd2);
        // tRAS then tRP on bank 2
        issue(3'd0, 2'd2, 15'h0100, t0);
        issue(3'd3, 2'd2, 15'h0, t1);
        chk("pre_tras", 32'(t1 - t0), 32'd12);
        issue(3'd0, 2'd2, 15'h0200, t2);
        chk("act_trp", 32'(t2 - t0), 32'd16);
        issue(3'd3, 2'd1, 15'h0, t0);
        issue(3'd3, 2'd2, 15'h0, t0);
        issue(3'd0, 2'd3, 15'h0300, t0);
        chk("open_03", 32'(bus.bank_open), 32'h9);
        issue(3'd4, 2'd0, 15'h0, t0);
        chk("prea_a10", 32'(bus.dfi_addr[10]), 32'd1);
        chk("prea_open", 32'(bus.bank_open), 32'h0);
        // refresh blocks ACT for tRFC
        issue(3'd5, 2'd0, 15'h0, t0);
        chk("ref_dfi", 32'({bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n}), 32'b001);
        issue(3'd0, 2'd1, 15'h0055, t1);
        chk("ref_trfc", 32'(t1 - t0), 32'd26);
        // illegal requests are taken in one cycle and flagged
        n0 = cyc; issue(3'd1, 2'd0, 15'h0, t0); chk("ill_rd_closed", 32'(t0 - n0), 32'd0);
        n0 = cyc; issue(3'd7, 2'd2, 15'h0, t0); chk("ill_op7", 32'(t0 - n0), 32'd0);
        n0 = cyc; issue(3'd0, 2'd1, 15'h0, t0); chk("ill_act_open", 32'(t0 - n0), 32'd0);
        chk("ill_err", 32'(bus.cmd_err), 32'd1);
        chk("ill_idle", 32'(dfi_now()), 32'(IDLE));
        n0 = cyc; issue(3'd5, 2'd0, 15'h0, t0); chk("ill_ref_open", 32'(t0 - n0), 32'd0);
        tick();
        // random traffic, requests held until accepted
        for (int i = 0; i < 400; i++) begin
            if (!bus.cmd_valid || last_acc) begin
                bus.cmd_valid = $urandom_range(0, 3) != 0;
                bus.cmd_op    = 3'($urandom_range(0, 7));
                bus.cmd_ba    = 2'($urandom_range(0, 3));
                bus.cmd_addr  = 15'($urandom);
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        // reset mid-operation with an open bank and tRCD pending
        issue(3'd4, 2'd0, 15'h0, t0);
        issue(3'd0, 2'd0, 15'h0777, t0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_idle", 32'(dfi_now()), 32'(IDLE));
        chk("rst_cke", 32'(bus.dfi_cke), 32'd0);
        chk("rst_open", 32'(bus.bank_open), 32'h0);
        n0 = cyc;
        issue(3'd0, 2'd0, 15'h0777, t0);
        chk("rst_act_second", 32'(t0 - n0), 32'd1);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ddr2_cmd_issuer.md
DDR2_CMD_ISSUER -- requirements
Module: ddr2_cmd_issuer

Interface
REQ-001 SHALL have parameters (name, default, meaning): T_RCD 4 ACT->RD/WR same bank, cycles; T_RP 4 PRE->ACT same bank; T_RAS 12 ACT->PRE same bank; T_RFC 26 REF->any command; T_CCD 2 RD/WR->RD/WR any bank.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 controller clock; rst in 1 reset, synchronous, active-high.
REQ-003 cmd_valid in 1 request present; cmd_ready out 1 request accepted this cycle when cmd_valid=1.
REQ-004 cmd_op in 3 opcode: 0 ACT, 1 RD, 2 WR, 3 PRE, 4 PREA, 5 REF, 6-7 illegal.
REQ-005 cmd_ba in 2 bank; cmd_addr in 15 row (ACT) or column (RD/WR).
REQ-006 dfi_cke out 1; dfi_cs_n out 2; dfi_ras_n, dfi_cas_n, dfi_we_n out 1 each; dfi_ba out 2; dfi_addr out 15; all drive the DFI control interface of the PHY.
REQ-007 cmd_err out 1 one-cycle pulse for a dropped illegal request; bank_open out 4 per-bank open-row status.

Function
REQ-008 All DFI outputs SHALL be registered; a request accepted in cycle N appears on DFI in cycle N+1 only, then returns to idle in N+2 unless another command is accepted in N+1.
REQ-009 Idle encoding: cs_n=2'b11, ras_n=cas_n=we_n=1, ba=0, addr=0.
REQ-010 Command encoding (cs_n=2'b10, then ras/cas/we): ACT 0/1/1 addr=cmd_addr; RD 1/0/1; WR 1/0/0; PRE 0/1/0 addr[10]=0; PREA 0/1/0 addr[10]=1; REF 0/0/1 ba=0 addr=0.
REQ-011 RD/WR SHALL drive addr=cmd_addr with addr[10] forced 0 (no auto-precharge); dfi_ba=cmd_ba for ACT/RD/WR/PRE.
REQ-012 dfi_cke SHALL be 0 while rst=1 and in the first cycle after rst falls, then 1; cmd_ready SHALL be 0 while dfi_cke=0.
REQ-013 Illegal request: op 6/7; ACT to open bank; RD/WR to closed bank; REF with any bank open.
REQ-014 Illegal request SHALL be accepted immediately (cmd_ready=1 when cke=1, regardless of timers), produce no DFI command, and pulse cmd_err in cycle N+1.
REQ-015 PRE to a closed bank SHALL be legal, gated by nothing, issued on DFI, and leave state unchanged.
REQ-016 Legal request cmd_ready SHALL be combinational from cmd_op/cmd_ba and timer state; cmd_ready=1 only when every applicable timer is zero.
REQ-017 Timing rule: with constraint T between commands X (accepted cycle N) and Y, Y SHALL be accepted no earlier than cycle N+T; counters load T-1 on acceptance of X and decrement to 0.
REQ-018 Per-bank timers rcd, ras, rp; global timers rfc, ccd; ACT loads rcd and ras of its bank; PRE to open bank loads rp of its bank; PREA loads rp of every bank open at acceptance; REF loads rfc; RD/WR load ccd.
REQ-019 Gating: ACT needs rp[ba]=0 and rfc=0; RD/WR need rcd[ba]=0, ccd=0, rfc=0; PRE needs ras[ba]=0 and rfc=0; PREA needs ras=0 on all open banks and rfc=0; REF needs rp=0 on all banks and rfc=0.
REQ-020 bank_open[b] SHALL set on ACT acceptance to b and clear on PRE to b or PREA, effective cycle N+1.
REQ-021 Timer width SHALL be $clog2(max parameter)+1 bits; counters saturate at 0, never wrap.
REQ-022 At most one command SHALL be accepted per cycle; no internal queueing; request held while cmd_ready=0 SHALL not be altered by the block.

Reset
REQ-023 rst=1 SHALL, at the next clk edge, force DFI idle encoding, dfi_cke=0, cmd_err=0, bank_open=0, all timers 0; applies mid-operation, with any in-flight command discarded.
REQ-024 cmd_ready SHALL be 0 while rst=1.

Verification
REQ-025 After reset, ACT ba=1 addr=0x1234 at N -> DFI cs_n=10 ras/cas/we=0/1/1 ba=1 addr=0x1234 at N+1; bank_open=4'b0010.
REQ-026 ACT ba=0 at N, RD ba=0 held valid -> cmd_ready low N+1..N+3, RD accepted N+4; second RD accepted N+6 (T_CCD=2).
REQ-027 ACT ba=2 at N, PRE ba=2 held -> accepted N+12; ACT ba=2 next accepted no earlier than N+16; PREA with banks 0,3 open -> addr[10]=1, bank_open=0.
REQ-028 REF at N with all closed -> ras/cas/we=0/0/1; any following command not accepted before N+26.
REQ-029 RD to closed bank, op 7, ACT to open bank, REF with a bank open -> each accepted in one cycle, cmd_err=1 at N+1, DFI idle.
REQ-030 rst asserted with rcd/rfc nonzero and banks open -> next cycle DFI idle, cke=0, bank_open=0; after release, ACT accepted on the second cycle without residual timer delay.
